uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Parametrised UART receiver, successor to the fixed 8-bit receiver in the CNN host link. It deserialises an asynchronous line into DATA_BITS-wide words, LSB first.

- Adds optional parity, 1 or 2 stop bits and 3-sample majority voting.
- Flags framing, parity and overrun errors.
- Presents words on a valid/ready handshake toward the command/weight loader.

## Interface
- CLKS_PER_BIT, 87: clk cycles per bit; legal 8..65535.
- DATA_BITS, 8: payload bits per frame; legal 5..16.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- serial_in  in  1  asynchronous RX line; idle high.
- rx_data  out  DATA_BITS  received word; stable while rx_valid=1.
- rx_valid  out  1  word available; held until accepted.
- rx_ready  in  1  consumer accepts when rx_valid & rx_ready.
- parity_err  out  1  qualifies rx_data; 1 = parity mismatch.
- frame_err  out  1  qualifies rx_data; 1 = a stop bit was sampled low.
- overrun_err  out  1  one-cycle pulse: a completed frame was dropped.
- busy  out  1  state machine is not IDLE.

## Operation
- serial_in passes through a 2-flop synchroniser; its output is rx_s.
- A 3-bit history shift register holds the last three rx_s values. A bit value is the majority of those 3 at the sample point.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: on rx_s=0, go to START with cnt=0.
- START: at cnt=(CLKS_PER_BIT-1)/2:
  - vote=0: cnt=0, go to DATA.
  - vote=1: glitch, return to IDLE; no flags.
- DATA: sample each bit at cnt=CLKS_PER_BIT-1, then cnt=0. Bit k goes into shift_reg[k], LSB first. After DATA_BITS samples, go to PARITY if PARITY≠0, else STOP.
- PARITY: sample one bit.
  - Odd mode: parity_err = ~(^{data,bit}).
  - Even mode: parity_err = ^{data,bit}.
- STOP: sample STOP_BITS bits. Any stop sample low sets frame_err.
  - After the last stop sample: deliver the word (see below).
  - Then go to IDLE if the last sample was 1, else to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. A held-low break line therefore yields exactly one frame_err word.
- Delivery:
  - rx_valid=0, or rx_valid & rx_ready in the same cycle: load rx_data, parity_err and frame_err; set rx_valid=1.
  - Otherwise: drop the new word, pulse overrun_err for 1 cycle, keep the old word.
- The handshake clears rx_valid and the error qualifiers on the cycle after acceptance.
- Counter width is $clog2(CLKS_PER_BIT). The counter never wraps, because every state resets cnt at its terminal count.
- Reset mid-frame: all state is cleared immediately and any partial word is lost. After reset release the FSM is in IDLE. A line low at release is treated as a start edge.

## Timing
- Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun_err=0, busy=0. State=IDLE, cnt=0, synchroniser and history = all-ones.
- Start detection: 2-cycle synchroniser delay after the serial_in falling edge.
- Sample points fall nominally at bit centre, offset by the constant synchroniser delay.
- rx_valid rises 1 cycle after the last stop-bit sample cycle.
- Minimum gap between delivered words is one frame time. A consumer holding rx_ready=1 never sees an overrun.
- busy is registered and tracks state≠IDLE with no extra delay.

## Structure
- Package uart_pkg holds:
  - The state enum, rx_state_t.
  - Parity constants: PAR_NONE, PAR_ODD, PAR_EVEN.
  - The function clog2_safe.
- Sub-module uart_sync2: 2-flop synchroniser with a reset value parameter (1 here). It is reused by the future TX and loopback blocks.
- Everything else is a single always_ff FSM plus a small output register stage.

## Test plan
- CLKS_PER_BIT=16, 8N1, send 0xA5 with rx_ready=1 → rx_data=0xA5 and a 1-cycle valid handshake. Errors=0. rx_valid rises 1 cycle after the stop-bit sample cycle.
- DATA_BITS=9, PARITY=2, send 0x1C3 with a correct parity bit → rx_data=0x1C3, parity_err=0. Repeat with the parity bit flipped → same data, parity_err=1.
- STOP_BITS=2, send 0x3C with the second stop bit low, then idle → frame_err=1 and one word delivered. The FSM reaches IDLE only after the line returns high. Hold the line low for 30 bit times → exactly one word.
- Inject a 4-cycle low glitch on the idle line → no rx_valid and busy returns to 0 by cycle (CLKS_PER_BIT-1)/2+3. Separately, a 1-cycle glitch at a data bit centre is outvoted: byte 0xFF is received intact.
- Hold rx_ready=0 and send 0x11 then 0x22 → rx_data remains 0x11, with one overrun_err pulse at the second delivery. Assert rx_ready → 0x11 is accepted and rx_valid drops.
- Assert rst during bit 4 of a frame → all outputs read their reset values within 1 cycle. After release, a fresh frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART receive/transmit family.
package uart_pkg;

  // Receiver state encoding
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  // Parity mode selectors
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Counter width helper that never returns zero, so tiny ranges still get a 1-bit counter
  function automatic int unsigned clog2_safe(input int unsigned value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Metastability filter: first flop may go metastable, second presents a clean level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_q    <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: majority-voted sampling, optional parity,
// 1 or 2 stop bits, valid/ready output with framing/parity/overrun reporting.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = clog2_safe(CLKS_PER_BIT);
  localparam int unsigned BIT_W = clog2_safe(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  logic                 w_rx_s;
  logic [2:0]           r_hist;
  logic                 w_vote;
  logic                 w_cnt_done;

  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [BIT_W-1:0]     r_bit_idx;
  logic [BIT_W-1:0]     w_bit_idx_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_par_err;
  logic                 w_par_err_nxt;
  logic                 r_frm_err;
  logic                 w_frm_err_nxt;
  logic                 r_busy;

  logic                 w_deliver;
  logic                 w_dlv_frm;

  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_overrun_err;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (serial_in),
    .o_q (w_rx_s)
  );

  // Last three synchronised samples; a bit value is their majority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= 3'b111;
    end else begin
      r_hist <= {r_hist[1:0], w_rx_s};
    end
  end

  assign w_vote     = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
  assign w_cnt_done = (r_cnt == CNT_LAST);

  // Frame state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_par_err <= w_par_err_nxt;
      r_frm_err <= w_frm_err_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state, bit timing and sampling; every state clears cnt at its terminal count
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_par_err_nxt = r_par_err;
    w_frm_err_nxt = r_frm_err;
    w_deliver     = 1'b0;
    w_dlv_frm     = r_frm_err;

    unique case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt   = ST_START;
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          w_par_err_nxt = 1'b0;
          w_frm_err_nxt = 1'b0;
        end
      end

      ST_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt   = '0;
          // A start bit that is no longer low at mid-bit was a glitch
          w_state_nxt = w_vote ? ST_IDLE : ST_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (w_cnt_done) begin
          w_cnt_nxt   = '0;
          // Shift in from the top so the first bit ends up at bit 0
          w_shift_nxt = {w_vote, r_shift[DATA_BITS-1:1]};
          if (r_bit_idx == DATA_LAST) begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + BIT_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_PARITY: begin
        if (w_cnt_done) begin
          w_cnt_nxt     = '0;
          w_par_err_nxt = (PARITY == PAR_ODD) ? ~(^{r_shift, w_vote}) : (^{r_shift, w_vote});
          w_state_nxt   = ST_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (w_cnt_done) begin
          w_cnt_nxt = '0;
          if (!w_vote) begin
            w_frm_err_nxt = 1'b1;
          end
          if (r_bit_idx == STOP_LAST) begin
            w_deliver     = 1'b1;
            w_dlv_frm     = r_frm_err | ~w_vote;
            w_bit_idx_nxt = '0;
            // A low final stop bit means a break; wait for the line to recover
            w_state_nxt   = w_vote ? ST_IDLE : ST_WAIT_IDLE;
          end else begin
            w_bit_idx_nxt = r_bit_idx + BIT_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_WAIT_IDLE: begin
        if (w_rx_s) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output word register: load on free slot or same-cycle accept, otherwise flag overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_parity_err  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_overrun_err <= 1'b0;
      if (w_deliver) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data    <= r_shift;
          r_parity_err <= r_par_err;
          r_frame_err  <= w_dlv_frm;
          r_rx_valid   <= 1'b1;
        end else begin
          r_overrun_err <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid   <= 1'b0;
        r_parity_err <= 1'b0;
        r_frame_err  <= 1'b0;
      end
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign parity_err  = r_parity_err;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;
  assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed + randomized bench for uart_rx_core: three configurations
// (8N1, 9-bit even parity, 8 data / 2 stop) checked against a frame-level model.
module tb_uart_rx_core;

  localparam int CPB = 16;

  typedef struct packed {
    logic [15:0] data;
    logic        perr;
    logic        ferr;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a_line = 1'b1, a_ready = 1'b1;
  logic [7:0] a_data;
  logic       a_valid, a_perr, a_ferr, a_ovr, a_busy;

  logic       b_line = 1'b1, b_ready = 1'b1;
  logic [8:0] b_data;
  logic       b_valid, b_perr, b_ferr, b_ovr, b_busy;

  logic       c_line = 1'b1, c_ready = 1'b1;
  logic [7:0] c_data;
  logic       c_valid, c_perr, c_ferr, c_ovr, c_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_start  = 0;

  word_t q_a[$];
  word_t q_b[$];
  word_t q_c[$];
  word_t wa, wb, wc;
  int    a_vcyc = 0, a_ovrn = 0, a_rise = 0, b_ovrn = 0, c_ovrn = 0;
  logic  a_vprev = 1'b0;

  always #5 clk = ~clk;

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .serial_in(a_line), .rx_data(a_data), .rx_valid(a_valid),
    .rx_ready(a_ready), .parity_err(a_perr), .frame_err(a_ferr), .overrun_err(a_ovr), .busy(a_busy));

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(2), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .serial_in(b_line), .rx_data(b_data), .rx_valid(b_valid),
    .rx_ready(b_ready), .parity_err(b_perr), .frame_err(b_ferr), .overrun_err(b_ovr), .busy(b_busy));

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .serial_in(c_line), .rx_data(c_data), .rx_valid(c_valid),
    .rx_ready(c_ready), .parity_err(c_perr), .frame_err(c_ferr), .overrun_err(c_ovr), .busy(c_busy));

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake monitor: records every accepted word plus valid/overrun activity
  always @(negedge clk) begin
    if (a_valid) a_vcyc++;
    if (a_ovr) a_ovrn++;
    if (b_ovr) b_ovrn++;
    if (c_ovr) c_ovrn++;
    if (a_valid && !a_vprev) a_rise = cyc;
    a_vprev = a_valid;
    if (a_valid && a_ready) begin
      wa.data = 16'(a_data); wa.perr = a_perr; wa.ferr = a_ferr; q_a.push_back(wa);
    end
    if (b_valid && b_ready) begin
      wb.data = 16'(b_data); wb.perr = b_perr; wb.ferr = b_ferr; q_b.push_back(wb);
    end
    if (c_valid && c_ready) begin
      wc.data = 16'(c_data); wc.perr = c_perr; wc.ferr = c_ferr; q_c.push_back(wc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected word from the frame contents: payload masked to nbits,
  // parity judged on the total count of ones, frame error if any stop bit is low
  function automatic word_t model(input logic [15:0] d, input int nbits, input int par,
                                  input logic pbit, input logic s1, input logic s2, input int nstop);
    word_t w;
    int ones;
    ones = 0;
    w.data = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < nbits) begin
        w.data[i] = d[i];
        if (d[i]) ones++;
      end
    end
    if (pbit) ones++;
    if (par == 0)      w.perr = 1'b0;
    else if (par == 1) w.perr = (ones % 2 == 0);
    else               w.perr = (ones % 2 == 1);
    w.ferr = !s1 || (nstop == 2 && !s2);
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int which, input logic v);
    case (which)
      0:       a_line = v;
      1:       b_line = v;
      default: c_line = v;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame; optionally invert one cycle at the centre of bit glitch_pos,
  // or assert rst at the centre of bit abort_pos and return early
  task automatic send_frame(input int which, input logic [15:0] d, input int nbits, input int par,
                            input logic pbit, input logic s1, input logic s2, input int nstop,
                            input int glitch_pos, input int abort_pos);
    logic bits[$];
    logic v;
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(d[i]);
    if (par != 0) bits.push_back(pbit);
    bits.push_back(s1);
    if (nstop == 2) bits.push_back(s2);
    for (int i = 0; i < bits.size(); i++) begin
      for (int c = 0; c < CPB; c++) begin
        @(posedge clk);
        #1;
        if (i == abort_pos && c == CPB / 2) begin
          set_line(which, 1'b1);
          rst = 1'b1;
          return;
        end
        v = bits[i];
        if (i == glitch_pos && c == CPB / 2) v = ~v;
        set_line(which, v);
        if (i == 0 && c == 0) t_start = cyc;
      end
    end
  endtask

  task automatic expect_word(input string tag, input int which, input word_t exp);
    word_t got;
    int sz;
    sz = (which == 0) ? q_a.size() : (which == 1) ? q_b.size() : q_c.size();
    check({tag, "_count"}, 32'(sz), 32'd1);
    if (sz > 0) begin
      if (which == 0)      got = q_a.pop_front();
      else if (which == 1) got = q_b.pop_front();
      else                 got = q_c.pop_front();
      check({tag, "_data"}, 32'(got.data), 32'(exp.data));
      check({tag, "_perr"}, 32'(got.perr), 32'(exp.perr));
      check({tag, "_ferr"}, 32'(got.ferr), 32'(exp.ferr));
    end
  endtask

  initial begin
    int          vc0, ov0, first, last, dly, e;
    logic [15:0] d;
    logic        pbit;
    word_t       exp_w;

    // Reset values
    idle(3);
    check("rst_data", 32'(a_data), 0);
    check("rst_valid", 32'(a_valid), 0);
    check("rst_perr", 32'(a_perr), 0);
    check("rst_ferr", 32'(a_ferr), 0);
    check("rst_ovr", 32'(a_ovr), 0);
    check("rst_busy", 32'(a_busy), 0);
    rst = 1'b0;
    idle(4);
    check("post_rst_busy", 32'(a_busy | b_busy | c_busy), 0);

    // 8N1 0xA5 with ready held high
    vc0 = a_vcyc;
    send_frame(0, 16'h00A5, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1, -1);
    idle(2 * CPB);
    expect_word("a5", 0, model(16'h00A5, 8, 0, 1'b0, 1'b1, 1'b1, 1));
    check("a5_valid_cycles", 32'(a_vcyc - vc0), 1);
    // Stop-bit centre is 152 cycles after the start edge; sync + vote + register add ~3
    dly = a_rise - t_start;
    check("a5_valid_rise", 32'(dly >= 153 && dly <= 157), 1);

    // 9-bit even parity: correct parity bit, then flipped
    d = 16'h01C3;
    pbit = ^d[8:0];
    send_frame(1, d, 9, 2, pbit, 1'b1, 1'b1, 1, -1, -1);
    idle(2 * CPB);
    expect_word("par_ok", 1, model(d, 9, 2, pbit, 1'b1, 1'b1, 1));
    send_frame(1, d, 9, 2, ~pbit, 1'b1, 1'b1, 1, -1, -1);
    idle(2 * CPB);
    expect_word("par_bad", 1, model(d, 9, 2, ~pbit, 1'b1, 1'b1, 1));

    // Two stop bits, second low, then a 30-bit break
    send_frame(2, 16'h003C, 8, 0, 1'b0, 1'b1, 1'b0, 2, -1, -1);
    idle(30 * CPB);
    check("brk_wait_busy", 32'(c_busy), 1);
    c_line = 1'b1;
    idle(4);
    check("brk_idle_busy", 32'(c_busy), 0);
    expect_word("brk", 2, model(16'h003C, 8, 0, 1'b0, 1'b1, 1'b0, 2));
    check("brk_extra_words", 32'(q_c.size()), 0);

    // 4-cycle glitch on an idle line
    vc0 = a_vcyc;
    first = -1;
    last = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      a_line = (c < 4) ? 1'b0 : 1'b1;
      if (a_busy) begin
        if (first < 0) first = c;
        last = c;
      end
    end
    check("glitch_busy_seen", 32'(first >= 0), 1);
    check("glitch_busy_len", 32'((last - first + 1) <= (CPB - 1) / 2 + 3), 1);
    check("glitch_busy_end", 32'(a_busy), 0);
    check("glitch_no_valid", 32'(a_vcyc - vc0), 0);

    // Single-cycle glitch at the centre of data bit 3 is outvoted
    send_frame(0, 16'h00FF, 8, 0, 1'b0, 1'b1, 1'b1, 1, 4, -1);
    idle(2 * CPB);
    expect_word("vote_ff", 0, model(16'h00FF, 8, 0, 1'b0, 1'b1, 1'b1, 1));

    // Overrun: consumer stalled across two frames
    a_ready = 1'b0;
    ov0 = a_ovrn;
    send_frame(0, 16'h0011, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1, -1);
    send_frame(0, 16'h0022, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1, -1);
    idle(2 * CPB);
    check("ovr_valid_held", 32'(a_valid), 1);
    check("ovr_data_kept", 32'(a_data), 32'h11);
    check("ovr_pulses", 32'(a_ovrn - ov0), 1);
    a_ready = 1'b1;
    idle(2);
    expect_word("ovr_accept", 0, model(16'h0011, 8, 0, 1'b0, 1'b1, 1'b1, 1));
    check("ovr_valid_drop", 32'(a_valid), 0);

    // Reset in the middle of data bit 4 with a word pending
    a_ready = 1'b0;
    d = 16'($urandom_range(1, 255));
    send_frame(0, d, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1, -1);
    idle(CPB);
    check("mid_pre_valid", 32'(a_valid), 1);
    send_frame(0, 16'h00C3, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1, 5);
    idle(1);
    check("mid_rst_data", 32'(a_data), 0);
    check("mid_rst_valid", 32'(a_valid), 0);
    check("mid_rst_perr", 32'(a_perr), 0);
    check("mid_rst_ferr", 32'(a_ferr), 0);
    check("mid_rst_ovr", 32'(a_ovr), 0);
    check("mid_rst_busy", 32'(a_busy), 0);
    idle(2);
    rst = 1'b0;
    a_ready = 1'b1;
    idle(2);
    send_frame(0, 16'h005A, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1, -1);
    idle(2 * CPB);
    expect_word("post_rst_5a", 0, model(16'h005A, 8, 0, 1'b0, 1'b1, 1'b1, 1));

    // Randomized frames on all three configurations
    for (int n = 0; n < 6; n++) begin
      d = 16'($urandom & 32'hFF);
      send_frame(0, d, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1, -1);
      idle(2 * CPB);
      expect_word("rnd_a", 0, model(d, 8, 0, 1'b0, 1'b1, 1'b1, 1));

      d = 16'($urandom & 32'h1FF);
      pbit = (^d[8:0]) ^ 1'($urandom & 1);
      send_frame(1, d, 9, 2, pbit, 1'b1, 1'b1, 1, -1, -1);
      idle(2 * CPB);
      expect_word("rnd_b", 1, model(d, 9, 2, pbit, 1'b1, 1'b1, 1));

      d = 16'($urandom & 32'hFF);
      e = int'($urandom_range(0, 2));
      send_frame(2, d, 8, 0, 1'b0, (e != 1), (e != 2), 2, -1, -1);
      c_line = 1'b1;
      idle(2 * CPB);
      expect_word("rnd_c", 2, model(d, 8, 0, 1'b0, (e != 1), (e != 2), 2));
    end

    check("no_ovr_b", 32'(b_ovrn), 0);
    check("no_ovr_c", 32'(c_ovrn), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
